bram_fifo: RTL and testbench

Single-clock, first-word-fall-through FIFO controller that owns both ports of the 1024x16 dual-port block RAM. Port A is the write side and port B is the read side. The block converts a valid/ready producer stream into RAM writes, prefetches RAM reads into a 2-entry output buffer, and presents a valid/ready consumer stream downstream. It is the standard buffering stage placed in front of any consumer of the RAM.

---
 rtl/fifo_pkg.sv | 7 +
 rtl/bram_fifo_out_buf.sv | 69 ++++++
 rtl/bram_fifo.sv | 89 ++++++++
 tb/tb_bram_fifo.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing constants for the block-RAM FIFO and its output buffer.
package fifo_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int LVL_W  = ADDR_W + 2;
endpackage

// File: rtl/bram_fifo_out_buf.sv
// Two-entry head/skid buffer that absorbs RAM read data and presents it
// as a first-word-fall-through valid/ready stream.
module bram_fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              pop,
  output logic [1:0]        buf_cnt
);

  logic              head_vld, skid_vld;
  logic [DATA_W-1:0] head, skid;
  logic              head_vld_n, skid_vld_n;
  logic [DATA_W-1:0] head_n, skid_n;

  assign pop      = head_vld && rd_ready;
  assign rd_valid = head_vld;
  assign rd_data  = head;
  assign buf_cnt  = {1'b0, head_vld} + {1'b0, skid_vld};

  always_comb begin
    head_vld_n = head_vld;
    skid_vld_n = skid_vld;
    head_n     = head;
    skid_n     = skid;
    if (pop) begin
      if (skid_vld) begin
        head_n     = skid;
        head_vld_n = 1'b1;
        skid_vld_n = 1'b0;
      end else begin
        head_vld_n = 1'b0;
      end
    end
    // Arriving word lands in whichever slot is free after the pop resolves.
    if (cap) begin
      if (!head_vld_n) begin
        head_n     = cap_data;
        head_vld_n = 1'b1;
      end else begin
        skid_n     = cap_data;
        skid_vld_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_vld <= 1'b0;
      skid_vld <= 1'b0;
      head     <= '0;
      skid     <= '0;
    end else begin
      head_vld <= head_vld_n;
      skid_vld <= skid_vld_n;
      head     <= head_n;
      skid     <= skid_n;
    end
  end

endmodule

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO controller driving both ports of a
// dual-port block RAM: port A writes, port B prefetches into a 2-entry buffer.
module bram_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ADDR_W = fifo_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_rd_ready,
  output logic [ADDR_W+1:0] o_level,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W-1:0] o_mem_addr_a,
  output logic [DATA_W-1:0] o_mem_din_a,
  output logic              o_mem_wen_a,
  output logic [ADDR_W-1:0] o_mem_addr_b,
  output logic [DATA_W-1:0] o_mem_din_b,
  output logic              o_mem_wen_b,
  input  logic [DATA_W-1:0] i_mem_dout_b
);

  localparam int LVL_W = ADDR_W + 2;

  logic [ADDR_W:0]  wr_ptr, rd_ptr, mem_occ;
  logic             full, ram_empty;
  logic             wr_fire, rd_issue, inflight, pop;
  logic [1:0]       buf_cnt;
  logic [2:0]       slots_used;
  logic [LVL_W-1:0] level;

  assign mem_occ   = wr_ptr - rd_ptr;
  assign full      = (mem_occ == {1'b1, {ADDR_W{1'b0}}});
  assign ram_empty = (wr_ptr == rd_ptr);

  assign o_wr_ready = !full;
  assign wr_fire    = i_wr_valid && !full && !i_rst;

  // Counting the pop that frees a slot this cycle lets a read be issued every
  // cycle in steady state; in-flight plus buffered words never exceed two.
  assign slots_used = 3'(inflight) + 3'(buf_cnt) - 3'(pop);
  assign rd_issue   = !ram_empty && !i_rst && (slots_used < 3'd2);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      level    <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      inflight <= rd_issue;
      level    <= level + LVL_W'(wr_fire) - LVL_W'(pop);
    end
  end

  assign o_mem_addr_a = wr_ptr[ADDR_W-1:0];
  assign o_mem_din_a  = i_wr_data;
  assign o_mem_wen_a  = wr_fire;
  assign o_mem_addr_b = rd_ptr[ADDR_W-1:0];
  assign o_mem_din_b  = '0;
  assign o_mem_wen_b  = 1'b0;

  assign o_level = level;
  assign o_full  = full;
  assign o_empty = (level == '0);

  bram_fifo_out_buf #(
    .DATA_W(DATA_W)
  ) u_out_buf (
    .clk     (i_clk),
    .rst     (i_rst),
    .cap     (inflight),
    .cap_data(i_mem_dout_b),
    .rd_ready(i_rd_ready),
    .rd_valid(o_rd_valid),
    .rd_data (o_rd_data),
    .pop     (pop),
    .buf_cnt (buf_cnt)
  );

endmodule

// File: tb/tb_bram_fifo.sv
// Bench for bram_fifo with a behavioural 1024x16 dual-port RAM and a
// queue-based scoreboard of accepted words.
module tb_bram_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_ready;
  logic [11:0] level;
  logic        full, empty;
  logic [9:0]  mem_addr_a, mem_addr_b;
  logic [15:0] mem_din_a, mem_din_b, mem_dout_b;
  logic        mem_wen_a, mem_wen_b;

  logic [15:0] ram [1024];

  int n_cmp = 0;
  int n_err = 0;
  int acc, outc;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen_a) ram[mem_addr_a] <= mem_din_a;
    if (mem_wen_b) ram[mem_addr_b] <= mem_din_b;
    mem_dout_b <= ram[mem_addr_b];
  end

  bram_fifo dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_valid  (wr_valid),
    .i_wr_data   (wr_data),
    .o_wr_ready  (wr_ready),
    .o_rd_valid  (rd_valid),
    .o_rd_data   (rd_data),
    .i_rd_ready  (rd_ready),
    .o_level     (level),
    .o_full      (full),
    .o_empty     (empty),
    .o_mem_addr_a(mem_addr_a),
    .o_mem_din_a (mem_din_a),
    .o_mem_wen_a (mem_wen_a),
    .o_mem_addr_b(mem_addr_b),
    .o_mem_din_b (mem_din_b),
    .o_mem_wen_b (mem_wen_b),
    .i_mem_dout_b(mem_dout_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, record handshakes against the scoreboard, advance.
  task automatic step(input logic wv, input logic [15:0] wd, input logic rr);
    logic wf, rf;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #2;
    wf = wv && wr_ready && !rst;
    rf = rd_valid && rr && !rst;
    if (wf) begin
      q.push_back(wd);
      acc++;
    end
    if (rf) begin
      outc++;
      n_cmp++;
      assert (q.size() != 0) else begin
        n_err++;
        $error("FAIL rd_unexpected: observed pop of 0x%0h expected no word", rd_data);
      end
      if (q.size() != 0) check("rd_data", 32'(rd_data), 32'(q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q.size() != 0 || !empty) && n < 5000) begin
      step(1'b0, 16'h0, 1'b1);
      n++;
    end
    check({tag, "_left"}, 32'(q.size()), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_level"}, 32'(level), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    #1;
    check("wen_a_in_rst", 32'(mem_wen_a), 32'd0);
    check("wen_b_in_rst", 32'(mem_wen_b), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    q.delete();
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
  endtask

  initial begin
    logic stable;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    acc = 0; outc = 0;
    @(posedge clk); #1;
    do_reset();

    // First-word latency: write at edge E, valid after E+2.
    step(1'b1, 16'h1234, 1'b1);
    check("lat_level_e", 32'(level), 32'd1);
    step(1'b0, 16'h0, 1'b1);
    check("lat_valid_e1", 32'(rd_valid), 32'd0);
    step(1'b0, 16'h0, 1'b1);
    check("lat_valid_e2", 32'(rd_valid), 32'd1);
    check("lat_data_e2", 32'(rd_data), 32'h1234);
    step(1'b0, 16'h0, 1'b1);
    check("lat_level_after", 32'(level), 32'd0);
    check("lat_empty_after", 32'(empty), 32'd1);

    // Reset in the middle of a stream discards everything.
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h100 + i), 1'b0);
    do_reset();
    step(1'b1, 16'hA5A5, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check("a5_valid", 32'(rd_valid), 32'd1);
    check("a5_data", 32'(rd_data), 32'hA5A5);
    drain("a5");

    // Fill: RAM plus head and skid hold 1026 words.
    acc = 0;
    for (int i = 0; i < 1030; i++) step(1'b1, 16'(i), 1'b0);
    check("fill_accepted", 32'(acc), 32'd1026);
    check("fill_level", 32'(level), 32'd1026);
    check("fill_wr_ready", 32'(wr_ready), 32'd0);
    check("fill_full", 32'(full), 32'd1);

    // Write and pop together at maximum occupancy.
    acc = 0;
    step(1'b1, 16'hBEEF, 1'b1);
    check("simul_refused", 32'(acc), 32'd0);
    check("simul_level1", 32'(level), 32'd1025);
    check("simul_ready", 32'(wr_ready), 32'd1);
    step(1'b1, 16'hBEEF, 1'b0);
    check("simul_accepted", 32'(acc), 32'd1);
    check("simul_level2", 32'(level), 32'd1026);
    outc = 0;
    drain("fill");
    check("fill_out_count", 32'(outc), 32'd1026);

    // Random consumer backpressure over a long stream.
    acc = 0; outc = 0;
    for (int n = 0; n < 20000 && acc < 4096; n++)
      step(1'b1, 16'(acc), 1'($urandom_range(0, 1)));
    check("bp_accepted", 32'(acc), 32'd4096);
    drain("bp");
    check("bp_out_count", 32'(outc), 32'd4096);

    // Primed steady state: one in and one out every cycle.
    for (int k = 0; k < 8; k++) step(1'b1, 16'(16'h8000 + k), 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 1'b0);
    check("tp_prime_level", 32'(level), 32'd8);
    acc = 0; outc = 0; stable = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      step(1'b1, 16'(16'h9000 + n), 1'b1);
      if (level != 12'd8) stable = 1'b0;
    end
    check("tp_in", 32'(acc), 32'd2000);
    check("tp_out", 32'(outc), 32'd2000);
    check("tp_level_const", 32'(stable), 32'd1);
    drain("tp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
